// File: rtl/fir_mac_seq_acc.sv
// Sequential FIR multiply-accumulate engine: one multiplier time-shared over the taps,
// with an optional symmetric pre-add, then round-half-up and saturation to the sample width.
module fir_mac_seq_acc #(
    parameter int unsigned TAPS        = 10,
    parameter int unsigned DATA_WIDTH  = 15,
    parameter int unsigned COEFF_WIDTH = 16,
    parameter int unsigned ACC_WIDTH   = 36,
    parameter int unsigned FRAC_SHIFT  = 15
) (
    input  logic                         iClk_12M,
    input  logic                         iRsn,
    input  logic                         iStart,
    input  logic                         iSymMode,
    input  logic [TAPS*DATA_WIDTH-1:0]   iDelayBus,
    input  logic [COEFF_WIDTH-1:0]       iCoeff,
    output logic [$clog2(TAPS)-1:0]      oCoeffAddr,
    output logic                         oBusy,
    output logic                         oValid,
    output logic [DATA_WIDTH-1:0]        oMac,
    output logic                         oSat
);

    localparam int unsigned CW     = $clog2(TAPS);
    localparam int unsigned PW     = DATA_WIDTH + 1 + COEFF_WIDTH;
    localparam int unsigned RW     = ACC_WIDTH + 1;
    localparam int unsigned RShAmt = (FRAC_SHIFT > 0) ? FRAC_SHIFT - 1 : 0;

    localparam logic signed [RW-1:0] RoundConst = (FRAC_SHIFT > 0) ? (RW'(1) <<< RShAmt) : '0;
    localparam logic signed [RW-1:0] MaxExt     = (RW'(1) <<< (DATA_WIDTH - 1)) - RW'(1);
    localparam logic signed [RW-1:0] MinExt     = -(RW'(1) <<< (DATA_WIDTH - 1));
    localparam logic [DATA_WIDTH-1:0] MaxOut    = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] MinOut    = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StMac, StDone} state_e;

    state_e                        state_q;
    logic [TAPS*DATA_WIDTH-1:0]    snap_q;
    logic                          sym_q;
    logic [CW-1:0]                 count_q;
    logic signed [ACC_WIDTH-1:0]   acc_q;

    logic [CW-1:0]                 mirror_idx;
    logic [CW-1:0]                 last_idx;
    logic                          last_cycle;
    int                            idx_a;
    int                            idx_b;
    logic signed [DATA_WIDTH-1:0]  samp_a;
    logic signed [DATA_WIDTH-1:0]  samp_b;
    logic signed [DATA_WIDTH:0]    pre_sum;
    logic signed [PW-1:0]          product;
    logic signed [ACC_WIDTH-1:0]   acc_next;
    logic signed [RW-1:0]          rounded;
    logic [DATA_WIDTH-1:0]         result;
    logic                          result_sat;

    always_comb begin
        mirror_idx = CW'(TAPS - 1) - count_q;
        last_idx   = sym_q ? CW'(TAPS / 2 - 1) : CW'(TAPS - 1);
        last_cycle = (count_q == last_idx);
        idx_a      = int'(count_q);
        idx_b      = int'(mirror_idx);
        samp_a     = snap_q[idx_a*DATA_WIDTH +: DATA_WIDTH];
        // The mirrored operand is forced to zero so one adder serves both modes.
        samp_b     = sym_q ? snap_q[idx_b*DATA_WIDTH +: DATA_WIDTH] : '0;
        pre_sum    = {samp_a[DATA_WIDTH-1], samp_a} + {samp_b[DATA_WIDTH-1], samp_b};
        product    = PW'(pre_sum) * PW'($signed(iCoeff));
        acc_next   = acc_q + ACC_WIDTH'(product);
        rounded    = (RW'(acc_next) + RoundConst) >>> FRAC_SHIFT;
        result     = rounded[DATA_WIDTH-1:0];
        result_sat = 1'b0;
        if (rounded > MaxExt) begin
            result     = MaxOut;
            result_sat = 1'b1;
        end else if (rounded < MinExt) begin
            result     = MinOut;
            result_sat = 1'b1;
        end
    end

    // count returns to zero on leaving MAC, so it doubles as the coefficient address.
    assign oCoeffAddr = count_q;

    always_ff @(posedge iClk_12M or negedge iRsn) begin
        if (!iRsn) begin
            state_q <= StIdle;
            snap_q  <= '0;
            sym_q   <= 1'b0;
            count_q <= '0;
            acc_q   <= '0;
            oBusy   <= 1'b0;
            oValid  <= 1'b0;
            oMac    <= '0;
            oSat    <= 1'b0;
        end else begin
            oValid <= 1'b0;
            case (state_q)
                StIdle, StDone: begin
                    if (iStart) begin
                        snap_q  <= iDelayBus;
                        sym_q   <= iSymMode;
                        acc_q   <= '0;
                        count_q <= '0;
                        oBusy   <= 1'b1;
                        state_q <= StMac;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StMac: begin
                    acc_q <= acc_next;
                    if (last_cycle) begin
                        count_q <= '0;
                        oBusy   <= 1'b0;
                        oValid  <= 1'b1;
                        oMac    <= result;
                        oSat    <= result_sat;
                        state_q <= StDone;
                    end else begin
                        count_q <= count_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                    count_q <= '0;
                    oBusy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_seq_acc.sv
// Self-checking bench for fir_mac_seq_acc: directed vectors, an arithmetic reference model
// compared every cycle, and hand-computed literal results for each scenario.
module tb_fir_mac_seq_acc;

    localparam int TAPS = 10;
    localparam int DW   = 15;
    localparam int CWID = 16;
    localparam int FRAC = 15;

    logic                 clk = 1'b0;
    logic                 iRsn = 1'b1;
    logic                 iStart = 1'b0;
    logic                 iSymMode = 1'b0;
    logic [TAPS*DW-1:0]   iDelayBus = '0;
    logic [CWID-1:0]      iCoeff;
    logic [3:0]           oCoeffAddr;
    logic                 oBusy;
    logic                 oValid;
    logic [DW-1:0]        oMac;
    logic                 oSat;

    logic signed [CWID-1:0] coeff_rom [16];

    int  n_cmp = 0;
    int  n_err = 0;
    bit  check_en = 1'b0;

    always #5 clk = ~clk;

    assign iCoeff = coeff_rom[oCoeffAddr];

    fir_mac_seq_acc #(
        .TAPS(TAPS), .DATA_WIDTH(DW), .COEFF_WIDTH(CWID), .ACC_WIDTH(36), .FRAC_SHIFT(FRAC)
    ) dut (
        .iClk_12M  (clk),
        .iRsn      (iRsn),
        .iStart    (iStart),
        .iSymMode  (iSymMode),
        .iDelayBus (iDelayBus),
        .iCoeff    (iCoeff),
        .oCoeffAddr(oCoeffAddr),
        .oBusy     (oBusy),
        .oValid    (oValid),
        .oMac      (oMac),
        .oSat      (oSat)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: plain sum of products over the captured samples, then round and clip.
    function automatic void model_result(input logic [TAPS*DW-1:0] bus, input logic sym,
                                         output longint mac, output logic sat);
        longint acc;
        longint s;
        longint r;
        int n;
        logic signed [DW-1:0] a;
        logic signed [DW-1:0] b;
        acc = 0;
        n = sym ? TAPS / 2 : TAPS;
        for (int k = 0; k < n; k++) begin
            a = bus[k*DW +: DW];
            s = longint'(a);
            if (sym) begin
                b = bus[(TAPS-1-k)*DW +: DW];
                s = s + longint'(b);
            end
            acc = acc + s * longint'(coeff_rom[k]);
        end
        r = (acc + (longint'(1) <<< (FRAC - 1))) >>> FRAC;
        if (r > 16383) begin
            mac = 16383; sat = 1'b1;
        end else if (r < -16384) begin
            mac = -16384; sat = 1'b1;
        end else begin
            mac = r; sat = 1'b0;
        end
    endfunction

    // Model state: remaining MAC cycles of the operation in flight and its pending result.
    int         m_left;
    int         m_n;
    logic       m_valid;
    logic       m_busy;
    logic [3:0] m_addr;
    longint     m_mac;
    logic       m_sat;
    longint     pend_mac;
    logic       pend_sat;

    always @(posedge clk or negedge iRsn) begin : model
        longint pm;
        logic ps;
        if (!iRsn) begin
            m_left  <= 0;
            m_n     <= 0;
            m_valid <= 1'b0;
            m_busy  <= 1'b0;
            m_addr  <= '0;
            m_mac   <= 0;
            m_sat   <= 1'b0;
        end else begin
            m_valid <= 1'b0;
            if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_valid <= 1'b1;
                    m_busy  <= 1'b0;
                    m_addr  <= '0;
                    m_mac   <= pend_mac;
                    m_sat   <= pend_sat;
                end else begin
                    m_addr <= 4'(m_n - m_left + 1);
                end
            end else if (iStart) begin
                model_result(iDelayBus, iSymMode, pm, ps);
                pend_mac <= pm;
                pend_sat <= ps;
                m_n      <= iSymMode ? TAPS / 2 : TAPS;
                m_left   <= iSymMode ? TAPS / 2 : TAPS;
                m_busy   <= 1'b1;
                m_addr   <= '0;
            end
        end
    end

    always @(negedge clk) begin
        if (iRsn && check_en) begin
            chk("cyc_valid", longint'(oValid), longint'(m_valid));
            chk("cyc_busy", longint'(oBusy), longint'(m_busy));
            chk("cyc_addr", longint'(oCoeffAddr), longint'(m_addr));
            chk("cyc_mac", longint'($signed(oMac)), m_mac);
            chk("cyc_sat", longint'(oSat), longint'(m_sat));
        end
    end

    task automatic set_all_d(input int val);
        for (int k = 0; k < TAPS; k++) iDelayBus[k*DW +: DW] = DW'(val);
    endtask

    task automatic set_all_c(input int val);
        for (int k = 0; k < 16; k++) coeff_rom[k] = (k < TAPS) ? CWID'(val) : '0;
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_busy"}, longint'(oBusy), 0);
        chk({tag, "_valid"}, longint'(oValid), 0);
        chk({tag, "_addr"}, longint'(oCoeffAddr), 0);
        chk({tag, "_mac"}, longint'($signed(oMac)), 0);
        chk({tag, "_sat"}, longint'(oSat), 0);
    endtask

    // Issues one start and checks latency, the address sequence and the literal result.
    task automatic run_op(input string name, input logic sym, input int exp_lat,
                          input longint exp_mac, input logic exp_sat);
        bit got;
        int lat;
        got = 1'b0;
        lat = 0;
        @(posedge clk); #1;
        iSymMode = sym;
        iStart   = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (i == 1) iStart = 1'b0;
            if (i < exp_lat) chk({name, "_addr_step"}, longint'(oCoeffAddr), longint'(i - 1));
            if (oValid) begin
                got = 1'b1;
                lat = i;
                break;
            end
        end
        if (!got) begin
            chk({name, "_timeout"}, 0, 1);
        end else begin
            chk({name, "_latency"}, longint'(lat), longint'(exp_lat));
            chk({name, "_mac"}, longint'($signed(oMac)), exp_mac);
            chk({name, "_sat"}, longint'(oSat), longint'(exp_sat));
            chk({name, "_model_mac"}, m_mac, exp_mac);
            chk({name, "_model_sat"}, longint'(m_sat), longint'(exp_sat));
        end
        @(posedge clk); #1;
        chk({name, "_valid_pulse"}, longint'(oValid), 0);
    endtask

    initial begin : stim
        int nv;
        int last;
        bit hit;
        set_all_c(0);
        #2 iRsn = 1'b0;
        #20;
        check_zero_outputs("reset");
        @(negedge clk);
        iRsn = 1'b1;
        check_en = 1'b1;

        // T1: unity-ish gain, normal mode
        set_all_d(1000);
        set_all_c(3277);
        run_op("t1", 1'b0, 11, 1000, 1'b0);

        // T2: positive and negative clipping
        set_all_d(16383);
        set_all_c(32767);
        run_op("t2_pos", 1'b0, 11, 16383, 1'b1);
        set_all_d(-16384);
        run_op("t2_neg", 1'b0, 11, -16384, 1'b1);

        // T3: symmetric mode; upper coefficients must not be used
        set_all_d(100);
        set_all_c(9999);
        for (int k = 0; k < 5; k++) coeff_rom[k] = 16'sd3277;
        run_op("t3_sym", 1'b1, 6, 100, 1'b0);

        // T6: impulse and round-half-up at exactly -0.5
        set_all_d(0);
        iDelayBus[3*DW +: DW] = 15'sd1000;
        set_all_c(5);
        coeff_rom[3] = -16'sd16384;
        run_op("t6_impulse", 1'b0, 11, -500, 1'b0);
        set_all_d(0);
        iDelayBus[0 +: DW] = -15'sd1;
        set_all_c(0);
        coeff_rom[0] = 16'sd16384;
        run_op("t6_round", 1'b0, 11, 0, 1'b0);

        // T4: start held high, delay line churning during MAC
        set_all_d(1000);
        set_all_c(3277);
        nv = 0;
        last = 0;
        @(posedge clk); #1;
        iSymMode = 1'b0;
        iStart   = 1'b1;
        for (int i = 1; i <= 34; i++) begin
            @(posedge clk); #1;
            set_all_d(-900 + i * 53);
            if (oValid) begin
                if (nv == 0) chk("t4_first_mac", longint'($signed(oMac)), 1000);
                else chk("t4_period", longint'(i - last), 11);
                last = i;
                nv++;
            end
        end
        iStart = 1'b0;
        chk("t4_result_count", longint'(nv), 3);
        repeat (15) @(posedge clk);

        // T5: reset in the middle of an operation
        set_all_d(1000);
        @(posedge clk); #1;
        iStart = 1'b1;
        @(posedge clk); #1;
        iStart = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (oCoeffAddr == 4'd4) begin
                hit = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        chk("t5_reached_count4", longint'(hit), 1);
        #2 iRsn = 1'b0;
        #1;
        check_zero_outputs("t5_in_reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        iRsn = 1'b1;
        nv = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (oValid) nv++;
        end
        chk("t5_no_valid", longint'(nv), 0);
        check_zero_outputs("t5_after");
        run_op("t5_t1_again", 1'b0, 11, 1000, 1'b0);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "time limit");
    end

endmodule
